// File: rtl/tron_mc_controller.sv
// Tron 16-bit multicycle controller: fetch, decode, exec, mem, writeback, trap.
// Ports: clk, reset (async active-low), instruction/instr_valid fetch port,
//   mem_ready; outputs fetch_req, reg_a/reg_b, immediate, cond, alu_op,
//   shift_op, bus_op, imm_mux, reg_write, flag_write, mem_req, mem_write,
//   pc_add, pc_jump, pc_branch, illegal_op, mem_timeout.
module tron_mc_controller #(
    parameter int WIDTH       = 16,
    parameter int REGBITS     = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        instruction,
    input  logic               instr_valid,
    input  logic               mem_ready,
    output logic               fetch_req,
    output logic [REGBITS-1:0] reg_a,
    output logic [REGBITS-1:0] reg_b,
    output logic [WIDTH-1:0]   immediate,
    output logic [3:0]         cond,
    output logic [3:0]         alu_op,
    output logic [1:0]         shift_op,
    output logic [2:0]         bus_op,
    output logic               imm_mux,
    output logic               reg_write,
    output logic               flag_write,
    output logic               mem_req,
    output logic               mem_write,
    output logic               pc_add,
    output logic               pc_jump,
    output logic               pc_branch,
    output logic               illegal_op,
    output logic               mem_timeout
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        K_ALU_R, K_ALU_I, K_LUI, K_LSH, K_LSHI, K_LOAD,
        K_STOR, K_JAL, K_JCOND, K_BCOND, K_ILL
    } kind_t;

    localparam int CW     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int TMO_I  = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_I);

    state_t             r_state, w_next;
    logic [15:0]        r_instr;
    kind_t              r_kind;
    logic [3:0]         r_alu;
    logic               r_mov, r_cmp;
    logic [REGBITS-1:0] r_reg_a, r_reg_b;
    logic [WIDTH-1:0]   r_imm;
    logic [3:0]         r_cond;
    logic [CW-1:0]      r_wait;

    logic [3:0]         w_op, w_ext, w_code;
    kind_t              w_kind;
    logic [3:0]         w_alu;
    logic               w_alu_ok, w_mov, w_cmp, w_tmo;
    logic [WIDTH-1:0]   w_imm;
    logic signed [7:0]  w_imm8s;
    logic signed [3:0]  w_imm4s;

    assign w_op    = r_instr[15:12];
    assign w_ext   = r_instr[7:4];
    // R-type selects the ALU function by ext, I-type by opcode
    assign w_code  = (w_op == 4'b0000) ? w_ext : w_op;
    assign w_imm8s = r_instr[7:0];
    assign w_imm4s = r_instr[3:0];
    assign w_tmo   = (MEM_TIMEOUT > 0) && (r_wait == TMO_LAST);

    always_comb begin
        w_alu_ok = 1'b1;
        w_alu    = 4'b0000;
        w_mov    = 1'b0;
        w_cmp    = 1'b0;
        case (w_code)
            4'b0101: w_alu = 4'b0000;
            4'b1001: w_alu = 4'b1000;
            4'b1011: begin w_alu = 4'b1000; w_cmp = 1'b1; end
            4'b0001: w_alu = 4'b0001;
            4'b0010: w_alu = 4'b0010;
            4'b0011: w_alu = 4'b0011;
            4'b1101: w_mov = 1'b1;
            default: w_alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_kind = K_ILL;
        case (w_op)
            4'b0000: w_kind = w_alu_ok ? K_ALU_R : K_ILL;
            4'b0100: begin
                case (w_ext)
                    4'b0000: w_kind = K_LOAD;
                    4'b0100: w_kind = K_STOR;
                    4'b1000: w_kind = K_JAL;
                    4'b1100: w_kind = K_JCOND;
                    default: w_kind = K_ILL;
                endcase
            end
            4'b1000: begin
                case (w_ext)
                    4'b0100:          w_kind = K_LSH;
                    4'b0000, 4'b0001: w_kind = K_LSHI;
                    default:          w_kind = K_ILL;
                endcase
            end
            4'b1100: w_kind = K_BCOND;
            4'b1111: w_kind = K_LUI;
            default: w_kind = w_alu_ok ? K_ALU_I : K_ILL;
        endcase
    end

    always_comb begin
        w_imm = WIDTH'(r_instr[7:0]);
        case (w_kind)
            K_ALU_I: begin
                // only the arithmetic immediates are signed
                if (w_op == 4'b0101 || w_alu == 4'b1000)
                    w_imm = WIDTH'(w_imm8s);
            end
            K_BCOND: w_imm = WIDTH'(w_imm8s);
            K_LSHI:  w_imm = WIDTH'(w_imm4s);
            K_LUI:   w_imm = WIDTH'({r_instr[7:0], 8'h00});
            default: w_imm = WIDTH'(r_instr[7:0]);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr <= '0;
            r_kind  <= K_ALU_R;
            r_alu   <= '0;
            r_mov   <= 1'b0;
            r_cmp   <= 1'b0;
            r_reg_a <= '0;
            r_reg_b <= '0;
            r_imm   <= '0;
            r_cond  <= '0;
            r_wait  <= '0;
        end else begin
            if (r_state == S_FETCH && instr_valid)
                r_instr <= instruction;
            if (r_state == S_DECODE) begin
                r_kind  <= w_kind;
                r_alu   <= w_alu;
                r_mov   <= w_mov;
                r_cmp   <= w_cmp;
                r_reg_a <= REGBITS'(r_instr[3:0]);
                r_reg_b <= REGBITS'(r_instr[11:8]);
                r_imm   <= w_imm;
                r_cond  <= (w_kind == K_JAL) ? 4'hF : r_instr[11:8];
            end
            // MEM is always entered from EXEC, so the count restarts at 0
            if (r_state == S_MEM)
                r_wait <= r_wait + 1'b1;
            else
                r_wait <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_FETCH;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (instr_valid) w_next = S_DECODE;
            S_DECODE: w_next = (w_kind == K_ILL) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (r_kind)
                    K_LOAD, K_STOR: w_next = S_MEM;
                    K_JAL:          w_next = S_WB;
                    default:        w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready)
                    w_next = (r_kind == K_LOAD) ? S_WB : S_FETCH;
                else if (w_tmo)
                    w_next = S_FETCH;
            end
            S_WB:    w_next = S_FETCH;
            S_TRAP:  w_next = S_FETCH;
            default: w_next = S_FETCH;
        endcase
    end

    assign reg_a     = r_reg_a;
    assign reg_b     = r_reg_b;
    assign immediate = r_imm;
    assign cond      = r_cond;
    assign shift_op  = 2'b00;

    always_comb begin
        fetch_req   = 1'b0;
        alu_op      = 4'b0000;
        bus_op      = 3'b000;
        imm_mux     = 1'b0;
        reg_write   = 1'b0;
        flag_write  = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        pc_add      = 1'b0;
        pc_jump     = 1'b0;
        pc_branch   = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
        case (r_state)
            S_FETCH: fetch_req = reset;
            S_EXEC: begin
                case (r_kind)
                    K_ALU_R, K_ALU_I, K_LUI: begin
                        alu_op     = r_alu;
                        imm_mux    = (r_kind != K_ALU_R);
                        reg_write  = !r_cmp;
                        flag_write = !r_mov;
                        pc_add     = 1'b1;
                        if (r_mov || r_kind == K_LUI)
                            bus_op = 3'b010;
                    end
                    K_LSH, K_LSHI: begin
                        bus_op    = 3'b001;
                        reg_write = 1'b1;
                        pc_add    = 1'b1;
                        imm_mux   = (r_kind == K_LSHI);
                    end
                    K_JAL: begin
                        reg_write = 1'b1;
                        bus_op    = 3'b100;
                    end
                    K_JCOND: pc_jump = 1'b1;
                    K_BCOND: begin
                        pc_branch = 1'b1;
                        imm_mux   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (r_kind == K_STOR) begin
                    mem_write = 1'b1;
                    bus_op    = 3'b101;
                end
                // a completing access takes priority over the timeout
                if (mem_ready) begin
                    pc_add = (r_kind == K_STOR);
                end else if (w_tmo) begin
                    mem_timeout = 1'b1;
                    pc_add      = 1'b1;
                end
            end
            S_WB: begin
                if (r_kind == K_LOAD) begin
                    bus_op    = 3'b011;
                    reg_write = 1'b1;
                    pc_add    = 1'b1;
                end else begin
                    pc_jump = 1'b1;
                end
            end
            S_TRAP: begin
                illegal_op = 1'b1;
                pc_add     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tron_mc_controller.sv
// Testbench for tron_mc_controller: randomized instruction stream against a
// cycle-trace reference model built from the instruction-set rules.
module tb_tron_mc_controller;

    localparam int TMO = 4;

    localparam int C_ILL = 0, C_R = 1, C_I = 2, C_LUI = 3, C_LSH = 4;
    localparam int C_LSHI = 5, C_LOAD = 6, C_STOR = 7, C_JAL = 8;
    localparam int C_JCOND = 9, C_BCOND = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instruction;
    logic        instr_valid, mem_ready;
    logic        fetch_req;
    logic [3:0]  reg_a, reg_b;
    logic [15:0] immediate;
    logic [3:0]  cond, alu_op;
    logic [1:0]  shift_op;
    logic [2:0]  bus_op;
    logic        imm_mux, reg_write, flag_write, mem_req, mem_write;
    logic        pc_add, pc_jump, pc_branch, illegal_op, mem_timeout;

    tron_mc_controller #(
        .WIDTH(16), .REGBITS(4), .MEM_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .instruction(instruction), .instr_valid(instr_valid),
        .mem_ready(mem_ready), .fetch_req(fetch_req),
        .reg_a(reg_a), .reg_b(reg_b), .immediate(immediate),
        .cond(cond), .alu_op(alu_op), .shift_op(shift_op),
        .bus_op(bus_op), .imm_mux(imm_mux), .reg_write(reg_write),
        .flag_write(flag_write), .mem_req(mem_req),
        .mem_write(mem_write), .pc_add(pc_add), .pc_jump(pc_jump),
        .pc_branch(pc_branch), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    logic [19:0] w_ctrl;
    assign w_ctrl = {fetch_req, alu_op, shift_op, bus_op, imm_mux,
                     reg_write, flag_write, mem_req, mem_write, pc_add,
                     pc_jump, pc_branch, illegal_op, mem_timeout};

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic        mr;
        logic [19:0] exp;
        bit          fld;
    } cyc_t;

    cyc_t        q[$];
    logic [15:0] cur;
    logic [3:0]  e_ra, e_rb, e_cond;
    logic [15:0] e_imm;

    // ALU function by R-type ext / I-type opcode; -1 = not an ALU code
    int alutab[16] = '{-1, 1, 2, 3, -1, 0, -1, -1,
                       -1, 8, -1, 8, -1, 0, -1, -1};
    int rx[7] = '{5, 9, 11, 1, 2, 3, 13};
    int ix[8] = '{5, 9, 11, 1, 2, 3, 13, 15};
    int mx[4] = '{0, 4, 8, 12};
    int sx[3] = '{4, 0, 1};

    function automatic int cls(input logic [15:0] i);
        int op, ext;
        op  = int'(i[15:12]);
        ext = int'(i[7:4]);
        if (op == 0)  return (alutab[ext] >= 0) ? C_R : C_ILL;
        if (op == 4) begin
            if (ext == 0)  return C_LOAD;
            if (ext == 4)  return C_STOR;
            if (ext == 8)  return C_JAL;
            if (ext == 12) return C_JCOND;
            return C_ILL;
        end
        if (op == 8) begin
            if (ext == 4) return C_LSH;
            if (ext <= 1) return C_LSHI;
            return C_ILL;
        end
        if (op == 12) return C_BCOND;
        if (op == 15) return C_LUI;
        return (alutab[op] >= 0) ? C_I : C_ILL;
    endfunction

    function automatic logic [19:0] mk(
        input bit fr, input int alu, input int bus, input bit im,
        input bit rw, input bit fw, input bit mq, input bit mw,
        input bit pa, input bit pj, input bit pb, input bit il,
        input bit tm);
        return {fr, 4'(alu), 2'b00, 3'(bus), im, rw, fw, mq, mw,
                pa, pj, pb, il, tm};
    endfunction

    function automatic void push(input logic iv, input logic mr,
                                 input logic [19:0] e, input bit f);
        cyc_t c;
        c.iv = iv; c.mr = mr; c.exp = e; c.fld = f;
        q.push_back(c);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Build the expected cycle trace for one instruction.
    // fw: idle fetch cycles, ml: MEM cycle index where mem_ready rises.
    task automatic build(input logic [15:0] ins, input int fw,
                         input int ml);
        int c, op, code, imm8, nib, alu;
        bit mov, cmp, st, tmo;
        q.delete();
        cur  = ins;
        c    = cls(ins);
        op   = int'(ins[15:12]);
        code = (op == 0) ? int'(ins[7:4]) : op;
        imm8 = int'(ins[7:0]);
        nib  = int'(ins[3:0]);
        e_ra   = ins[3:0];
        e_rb   = ins[11:8];
        e_cond = (c == C_JAL) ? 4'hF : ins[11:8];
        case (c)
            C_I:     e_imm = (op == 5 || op == 9 || op == 11) ?
                             16'(imm8 < 128 ? imm8 : imm8 + 65280) :
                             16'(imm8);
            C_BCOND: e_imm = 16'(imm8 < 128 ? imm8 : imm8 + 65280);
            C_LSHI:  e_imm = 16'(nib < 8 ? nib : nib + 65520);
            C_LUI:   e_imm = 16'(imm8 * 256);
            default: e_imm = 16'(imm8);
        endcase
        for (int k = 0; k < fw; k++)
            push(1'b0, rb(), mk(1,0,0,0,0,0,0,0,0,0,0,0,0), 0);
        push(1'b1, rb(), mk(1,0,0,0,0,0,0,0,0,0,0,0,0), 0);
        push(rb(), rb(), '0, 0);
        if (c == C_ILL) begin
            push(rb(), rb(), mk(0,0,0,0,0,0,0,0,1,0,0,1,0), 0);
            return;
        end
        case (c)
            C_R, C_I, C_LUI: begin
                mov = (c != C_LUI) && (code == 13);
                cmp = (c != C_LUI) && (code == 11);
                alu = (c == C_LUI) ? 0 : alutab[code];
                push(rb(), rb(), mk(0, alu, (mov || c == C_LUI) ? 2 : 0,
                     c != C_R, !cmp, !mov, 0, 0, 1, 0, 0, 0, 0), 1);
            end
            C_LSH, C_LSHI:
                push(rb(), rb(), mk(0,0,1,c == C_LSHI,1,0,0,0,1,0,0,0,0), 1);
            C_JAL:
                push(rb(), rb(), mk(0,0,4,0,1,0,0,0,0,0,0,0,0), 1);
            C_JCOND:
                push(rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1,0,0,0), 1);
            C_BCOND:
                push(rb(), rb(), mk(0,0,0,1,0,0,0,0,0,0,1,0,0), 1);
            default:
                push(rb(), rb(), '0, 1);
        endcase
        if (c == C_LOAD || c == C_STOR) begin
            st  = (c == C_STOR);
            tmo = 0;
            for (int k = 0; k < 64; k++) begin
                if (k == ml) begin
                    push(rb(), 1'b1,
                         mk(0,0,st ? 5 : 0,0,0,0,1,st,st,0,0,0,0), 0);
                    break;
                end else if (k == TMO - 1) begin
                    push(rb(), 1'b0,
                         mk(0,0,st ? 5 : 0,0,0,0,1,st,1,0,0,0,1), 0);
                    tmo = 1;
                    break;
                end
                push(rb(), 1'b0, mk(0,0,st ? 5 : 0,0,0,0,1,st,0,0,0,0,0), 0);
            end
            if (c == C_LOAD && !tmo)
                push(rb(), rb(), mk(0,0,3,0,1,0,0,0,1,0,0,0,0), 0);
        end
        if (c == C_JAL)
            push(rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1,0,0,0), 0);
    endtask

    task automatic play();
        foreach (q[k]) begin
            @(negedge clk);
            instr_valid = q[k].iv;
            mem_ready   = q[k].mr;
            instruction = q[k].iv ? cur : 16'($urandom);
            #1;
            chk($sformatf("ctrl %h cyc%0d", cur, k), w_ctrl, q[k].exp);
            if (q[k].fld) begin
                chk($sformatf("reg_a %h", cur), reg_a, e_ra);
                chk($sformatf("reg_b %h", cur), reg_b, e_rb);
                chk($sformatf("imm %h", cur), immediate, e_imm);
                chk($sformatf("cond %h", cur), cond, e_cond);
            end
        end
    endtask

    task automatic run1(input logic [15:0] ins, input int fw,
                        input int ml);
        build(ins, fw, ml);
        play();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ctrl"}, w_ctrl, '0);
        chk({tag, " reg_a"}, reg_a, '0);
        chk({tag, " reg_b"}, reg_b, '0);
        chk({tag, " imm"}, immediate, '0);
        chk({tag, " cond"}, cond, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ins;
        int sel;
        reset       = 1'b0;
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        instruction = '0;
        @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        run1(16'h0355, 0, 0);
        run1(16'h52FF, 0, 0);
        run1(16'h22FF, 1, 0);
        run1(16'hF112, 0, 0);
        run1(16'h4406, 0, 2);
        run1(16'h4746, 0, 99);
        run1(16'h4746, 0, 3);
        run1(16'h4406, 0, 3);
        run1(16'h0E77, 0, 0);
        run1(16'h44A0, 2, 0);
        run1(16'h8182, 0, 0);
        run1(16'h8349, 0, 0);

        // reset pulled low in the middle of a memory access
        build(16'h4406, 0, 99);
        q = q[0:4];
        play();
        @(negedge clk);
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        #1;
        chk("pre-reset mem", w_ctrl, mk(0,0,0,0,0,0,1,0,0,0,0,0,0));
        #2;
        reset = 1'b0;
        #1;
        chk_zero("mid-mem reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post-reset fetch", w_ctrl, mk(1,0,0,0,0,0,0,0,0,0,0,0,0));

        for (int t = 0; t < 200; t++) begin
            ins = 16'($urandom);
            sel = $urandom_range(0, 20);
            if (sel <= 6) begin
                ins[15:12] = 4'b0000;
                ins[7:4]   = 4'(rx[sel]);
            end else if (sel <= 14) begin
                ins[15:12] = 4'(ix[sel - 7]);
            end else if (sel <= 16) begin
                ins[15:12] = 4'b0100;
                ins[7:4]   = 4'(mx[$urandom_range(0, 3)]);
            end else if (sel == 17) begin
                ins[15:12] = 4'b1000;
                ins[7:4]   = 4'(sx[$urandom_range(0, 2)]);
            end else if (sel == 18) begin
                ins[15:12] = 4'b1100;
            end
            run1(ins, $urandom_range(0, 2), $urandom_range(0, 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
